// File: rtl/a_inverse_multiplier.sv
// A-inverse multiplier: A^-1 = R^-1 * Q^H for a 4x4 complex matrix, one time-shared complex MAC.
// Latency: 40 MAC cycles after the start decision; element (0,0) appears 5 cycles after it, last one 41 cycles after.
// Backpressure: none on the output stream; Q_valid/R_inverse_done are ignored while busy (Q_ready low).
module a_inverse_multiplier #(
    parameter  int INT_LENGTH  = 7,
    parameter  int FRAC_LENGTH = 11,
    localparam int W           = INT_LENGTH + FRAC_LENGTH
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                Q_valid,
    input  logic signed [W-1:0] Q_re_in,
    input  logic signed [W-1:0] Q_im_in,
    output logic                Q_ready,
    input  logic                R_inverse_done,
    input  logic signed [W-1:0] R_inv_re_11,
    input  logic signed [W-1:0] R_inv_re_12,
    input  logic signed [W-1:0] R_inv_re_13,
    input  logic signed [W-1:0] R_inv_re_14,
    input  logic signed [W-1:0] R_inv_re_22,
    input  logic signed [W-1:0] R_inv_re_23,
    input  logic signed [W-1:0] R_inv_re_24,
    input  logic signed [W-1:0] R_inv_re_33,
    input  logic signed [W-1:0] R_inv_re_34,
    input  logic signed [W-1:0] R_inv_re_44,
    input  logic signed [W-1:0] R_inv_im_12,
    input  logic signed [W-1:0] R_inv_im_13,
    input  logic signed [W-1:0] R_inv_im_14,
    input  logic signed [W-1:0] R_inv_im_23,
    input  logic signed [W-1:0] R_inv_im_24,
    input  logic signed [W-1:0] R_inv_im_34,
    output logic signed [W-1:0] Ainv_re,
    output logic signed [W-1:0] Ainv_im,
    output logic [1:0]          Ainv_row,
    output logic [1:0]          Ainv_col,
    output logic                Ainv_valid,
    output logic                busy,
    output logic                Ainv_done
);

    localparam int ACC_W = 2*W + 3;

    typedef enum logic [1:0] {IDLE, WAIT_Q, MAC, DONE} state_t;

    state_t                  r_state;
    logic [3:0]              r_q_cnt;
    logic                    r_q_loaded;
    logic signed [W-1:0]     r_q_re  [16];
    logic signed [W-1:0]     r_q_im  [16];
    // R^-1 stored as a full 4x4 (index {row,col}); lower triangle and diagonal imag stay 0
    logic signed [W-1:0]     r_rr    [16];
    logic signed [W-1:0]     r_ri    [16];
    logic [1:0]              r_i, r_j, r_k;
    logic signed [ACC_W-1:0] r_acc_re, r_acc_im;
    logic signed [W-1:0]     r_out_re, r_out_im;
    logic [1:0]              r_out_row, r_out_col;
    logic                    r_out_vld, r_out_done;

    logic                    w_busy;
    logic                    w_q_acc;
    logic signed [W-1:0]     w_cap_re [16];
    logic signed [W-1:0]     w_cap_im [16];
    logic signed [W-1:0]     w_rr, w_ri, w_qr, w_qi;
    logic signed [2*W-1:0]   w_p_rr, w_p_ii, w_p_ir, w_p_ri;
    logic signed [ACC_W-1:0] w_term_re, w_term_im;
    logic signed [ACC_W-1:0] w_base_re, w_base_im;
    logic signed [ACC_W-1:0] w_sum_re, w_sum_im;
    logic signed [ACC_W-1:0] w_shift_re, w_shift_im;

    // Clamp a shifted accumulator value into the W-bit signed output range
    function automatic logic signed [W-1:0] f_sat(input logic signed [ACC_W-1:0] v);
        if (!v[ACC_W-1] && (|v[ACC_W-2:W-1]))
            f_sat = {1'b0, {(W-1){1'b1}}};
        else if (v[ACC_W-1] && !(&v[ACC_W-2:W-1]))
            f_sat = {1'b1, {(W-1){1'b0}}};
        else
            f_sat = v[W-1:0];
    endfunction

    assign w_busy     = (r_state == MAC) || (r_state == DONE);
    assign busy       = w_busy;
    assign Q_ready    = !w_busy;
    assign w_q_acc    = Q_valid && !w_busy;

    assign Ainv_re    = r_out_re;
    assign Ainv_im    = r_out_im;
    assign Ainv_row   = r_out_row;
    assign Ainv_col   = r_out_col;
    assign Ainv_valid = r_out_vld;
    assign Ainv_done  = r_out_done;

    // Map the upper-triangular R^-1 ports onto a zero-filled 4x4 image for capture
    always_comb begin
        for (int n = 0; n < 16; n++) begin
            w_cap_re[n] = '0;
            w_cap_im[n] = '0;
        end
        w_cap_re[0]  = R_inv_re_11;
        w_cap_re[1]  = R_inv_re_12;
        w_cap_re[2]  = R_inv_re_13;
        w_cap_re[3]  = R_inv_re_14;
        w_cap_re[5]  = R_inv_re_22;
        w_cap_re[6]  = R_inv_re_23;
        w_cap_re[7]  = R_inv_re_24;
        w_cap_re[10] = R_inv_re_33;
        w_cap_re[11] = R_inv_re_34;
        w_cap_re[15] = R_inv_re_44;
        w_cap_im[1]  = R_inv_im_12;
        w_cap_im[2]  = R_inv_im_13;
        w_cap_im[3]  = R_inv_im_14;
        w_cap_im[6]  = R_inv_im_23;
        w_cap_im[7]  = R_inv_im_24;
        w_cap_im[11] = R_inv_im_34;
    end

    // MAC datapath: R^-1[i][k] * conj(Q[j][k]) at full precision, added to the running sum
    always_comb begin
        w_rr      = r_rr[{r_i, r_k}];
        w_ri      = r_ri[{r_i, r_k}];
        w_qr      = r_q_re[{r_j, r_k}];
        w_qi      = r_q_im[{r_j, r_k}];
        w_p_rr    = w_rr * w_qr;
        w_p_ii    = w_ri * w_qi;
        w_p_ir    = w_ri * w_qr;
        w_p_ri    = w_rr * w_qi;
        w_term_re = {{3{w_p_rr[2*W-1]}}, w_p_rr} + {{3{w_p_ii[2*W-1]}}, w_p_ii};
        w_term_im = {{3{w_p_ir[2*W-1]}}, w_p_ir} - {{3{w_p_ri[2*W-1]}}, w_p_ri};
        // first k of an element starts a fresh sum
        w_base_re = (r_k == r_i) ? '0 : r_acc_re;
        w_base_im = (r_k == r_i) ? '0 : r_acc_im;
        w_sum_re  = w_base_re + w_term_re;
        w_sum_im  = w_base_im + w_term_im;
        w_shift_re = w_sum_re >>> FRAC_LENGTH;
        w_shift_im = w_sum_im >>> FRAC_LENGTH;
    end

    // Q memory write; contents are deliberately not reset
    always_ff @(posedge CLK) begin
        if (w_q_acc) begin
            r_q_re[r_q_cnt] <= Q_re_in;
            r_q_im[r_q_cnt] <= Q_im_in;
        end
    end

    // Control FSM, Q load tracking, R^-1 capture, accumulator and registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= IDLE;
            r_q_cnt    <= '0;
            r_q_loaded <= 1'b0;
            for (int n = 0; n < 16; n++) begin
                r_rr[n] <= '0;
                r_ri[n] <= '0;
            end
            r_i        <= '0;
            r_j        <= '0;
            r_k        <= '0;
            r_acc_re   <= '0;
            r_acc_im   <= '0;
            r_out_re   <= '0;
            r_out_im   <= '0;
            r_out_row  <= '0;
            r_out_col  <= '0;
            r_out_vld  <= 1'b0;
            r_out_done <= 1'b0;
        end else begin
            r_out_vld  <= 1'b0;
            r_out_done <= 1'b0;

            if (w_q_acc) begin
                r_q_cnt <= r_q_cnt + 4'd1;
                if (r_q_cnt == 4'd15)
                    r_q_loaded <= 1'b1;
                else if (r_q_cnt == 4'd0)
                    r_q_loaded <= 1'b0;
            end

            case (r_state)
                IDLE, WAIT_Q: begin
                    if (R_inverse_done) begin
                        for (int n = 0; n < 16; n++) begin
                            r_rr[n] <= w_cap_re[n];
                            r_ri[n] <= w_cap_im[n];
                        end
                    end
                    if (r_q_loaded && (R_inverse_done || r_state == WAIT_Q)) begin
                        r_state <= MAC;
                        r_i     <= '0;
                        r_j     <= '0;
                        r_k     <= '0;
                    end else if (R_inverse_done) begin
                        r_state <= WAIT_Q;
                    end
                end
                MAC: begin
                    r_acc_re <= w_sum_re;
                    r_acc_im <= w_sum_im;
                    if (r_k == 2'd3) begin
                        r_out_re  <= f_sat(w_shift_re);
                        r_out_im  <= f_sat(w_shift_im);
                        r_out_row <= r_i;
                        r_out_col <= r_j;
                        r_out_vld <= 1'b1;
                        if (r_i == 2'd3 && r_j == 2'd3) begin
                            r_out_done <= 1'b1;
                            r_state    <= DONE;
                        end else if (r_j == 2'd3) begin
                            r_i <= r_i + 2'd1;
                            r_j <= '0;
                            r_k <= r_i + 2'd1;
                        end else begin
                            r_j <= r_j + 2'd1;
                            r_k <= r_i;
                        end
                    end else begin
                        r_k <= r_k + 2'd1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_a_inverse_multiplier.sv
// Bench for a_inverse_multiplier: directed runs, scoreboard of expected elements with arrival cycles.
// Driver pushes expectations when it starts a run; a forked monitor pops on every Ainv_valid.
// All waits are fixed cycle counts, so the run always ends on its own.
module tb_a_inverse_multiplier;
    localparam int W   = 18;
    localparam int BIG = 1000000;

    logic CLK = 1'b0;
    logic RST;
    logic Q_valid, Q_ready, R_inverse_done;
    logic signed [W-1:0] Q_re_in, Q_im_in;
    logic signed [W-1:0] R_inv_re_11, R_inv_re_12, R_inv_re_13, R_inv_re_14;
    logic signed [W-1:0] R_inv_re_22, R_inv_re_23, R_inv_re_24;
    logic signed [W-1:0] R_inv_re_33, R_inv_re_34, R_inv_re_44;
    logic signed [W-1:0] R_inv_im_12, R_inv_im_13, R_inv_im_14;
    logic signed [W-1:0] R_inv_im_23, R_inv_im_24, R_inv_im_34;
    logic signed [W-1:0] Ainv_re, Ainv_im;
    logic [1:0] Ainv_row, Ainv_col;
    logic Ainv_valid, busy, Ainv_done;

    a_inverse_multiplier dut (
        .CLK(CLK), .RST(RST),
        .Q_valid(Q_valid), .Q_re_in(Q_re_in), .Q_im_in(Q_im_in), .Q_ready(Q_ready),
        .R_inverse_done(R_inverse_done),
        .R_inv_re_11(R_inv_re_11), .R_inv_re_12(R_inv_re_12), .R_inv_re_13(R_inv_re_13),
        .R_inv_re_14(R_inv_re_14), .R_inv_re_22(R_inv_re_22), .R_inv_re_23(R_inv_re_23),
        .R_inv_re_24(R_inv_re_24), .R_inv_re_33(R_inv_re_33), .R_inv_re_34(R_inv_re_34),
        .R_inv_re_44(R_inv_re_44),
        .R_inv_im_12(R_inv_im_12), .R_inv_im_13(R_inv_im_13), .R_inv_im_14(R_inv_im_14),
        .R_inv_im_23(R_inv_im_23), .R_inv_im_24(R_inv_im_24), .R_inv_im_34(R_inv_im_34),
        .Ainv_re(Ainv_re), .Ainv_im(Ainv_im), .Ainv_row(Ainv_row), .Ainv_col(Ainv_col),
        .Ainv_valid(Ainv_valid), .busy(busy), .Ainv_done(Ainv_done)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int row;
        int col;
        int re;
        int im;
        int cyc;
        int done;
    } exp_t;

    exp_t sb[$];
    int n_pass  = 0;
    int n_total = 0;

    int g_rre [4][4];
    int g_rim [4][4];
    int g_qre [16];
    int g_qim [16];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int sat(input longint v);
        if (v > 131071) return 131071;
        if (v < -131072) return -131072;
        return int'(v);
    endfunction

    // Reference: sum over k>=i of R[i][k]*conj(Q[j][k]); diagonal of R is real
    task automatic model(input int i, input int j, output int re, output int im);
        longint sr, si, rr, ri, qr, qi;
        sr = 0;
        si = 0;
        for (int k = i; k < 4; k++) begin
            rr = longint'(g_rre[i][k]);
            ri = (k == i) ? 64'sd0 : longint'(g_rim[i][k]);
            qr = longint'(g_qre[j*4+k]);
            qi = longint'(g_qim[j*4+k]);
            sr += rr*qr + ri*qi;
            si += ri*qr - rr*qi;
        end
        re = sat(sr >>> 11);
        im = sat(si >>> 11);
    endtask

    // Push every element of a run started at decision cycle s that is due before the cutoff
    task automatic push_run(input int s, input int cutoff);
        int t;
        exp_t e;
        t = 0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                t += 4 - i;
                e.row = i;
                e.col = j;
                model(i, j, e.re, e.im);
                e.cyc = s + t + 1;
                e.done = (i == 3 && j == 3) ? 1 : 0;
                if (e.cyc < cutoff) sb.push_back(e);
            end
        end
    endtask

    task automatic drive_r();
        R_inv_re_11 = W'(g_rre[0][0]); R_inv_re_12 = W'(g_rre[0][1]);
        R_inv_re_13 = W'(g_rre[0][2]); R_inv_re_14 = W'(g_rre[0][3]);
        R_inv_re_22 = W'(g_rre[1][1]); R_inv_re_23 = W'(g_rre[1][2]);
        R_inv_re_24 = W'(g_rre[1][3]); R_inv_re_33 = W'(g_rre[2][2]);
        R_inv_re_34 = W'(g_rre[2][3]); R_inv_re_44 = W'(g_rre[3][3]);
        R_inv_im_12 = W'(g_rim[0][1]); R_inv_im_13 = W'(g_rim[0][2]);
        R_inv_im_14 = W'(g_rim[0][3]); R_inv_im_23 = W'(g_rim[1][2]);
        R_inv_im_24 = W'(g_rim[1][3]); R_inv_im_34 = W'(g_rim[2][3]);
    endtask

    task automatic drive_junk(input int v);
        R_inv_re_11 = W'(v); R_inv_re_12 = W'(v); R_inv_re_13 = W'(v); R_inv_re_14 = W'(v);
        R_inv_re_22 = W'(v); R_inv_re_23 = W'(v); R_inv_re_24 = W'(v);
        R_inv_re_33 = W'(v); R_inv_re_34 = W'(v); R_inv_re_44 = W'(v);
        R_inv_im_12 = W'(v); R_inv_im_13 = W'(v); R_inv_im_14 = W'(v);
        R_inv_im_23 = W'(v); R_inv_im_24 = W'(v); R_inv_im_34 = W'(v);
    endtask

    task automatic load_q(input int lo, input int hi);
        for (int n = lo; n <= hi; n++) begin
            Q_valid = 1'b1;
            Q_re_in = W'(g_qre[n]);
            Q_im_in = W'(g_qim[n]);
            step();
        end
        Q_valid = 1'b0;
    endtask

    task automatic set_identity();
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                g_rre[i][k] = (i == k) ? 2048 : 0;
                g_rim[i][k] = 0;
                g_qre[i*4+k] = (i == k) ? 2048 : 0;
                g_qim[i*4+k] = 0;
            end
    endtask

    // Pulse R_inverse_done with Q already loaded; s is the decision cycle
    task automatic start_run(input int cut_rel, output int s);
        drive_r();
        R_inverse_done = 1'b1;
        s = cyc;
        push_run(s, s + cut_rel);
        step();
        R_inverse_done = 1'b0;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge CLK);
            if (Ainv_valid) begin
                n_total++;
                if (sb.size() == 0) begin
                    $display("FAIL unexpected_valid: row %0d col %0d re %0d im %0d at cycle %0d, expected no element",
                             Ainv_row, Ainv_col, Ainv_re, Ainv_im, cyc);
                end else begin
                    e = sb.pop_front();
                    if (int'(Ainv_row) == e.row && int'(Ainv_col) == e.col &&
                        int'(Ainv_re) == e.re && int'(Ainv_im) == e.im &&
                        cyc == e.cyc && int'(Ainv_done) == e.done)
                        n_pass++;
                    else
                        $display("FAIL elem: got (%0d,%0d) re %0d im %0d cyc %0d done %0d; expected (%0d,%0d) re %0d im %0d cyc %0d done %0d",
                                 Ainv_row, Ainv_col, Ainv_re, Ainv_im, cyc, Ainv_done,
                                 e.row, e.col, e.re, e.im, e.cyc, e.done);
                end
            end else if (Ainv_done) begin
                n_total++;
                $display("FAIL stray_done: Ainv_done=1 without Ainv_valid at cycle %0d, expected 0", cyc);
            end
        end
    endtask

    initial begin
        int s, t;
        fork
            monitor();
        join_none

        RST = 1'b1;
        Q_valid = 1'b0;
        Q_re_in = '0;
        Q_im_in = '0;
        R_inverse_done = 1'b0;
        drive_junk(0);
        step();
        step();
        chk("rst_valid", int'(Ainv_valid), 0);
        chk("rst_done", int'(Ainv_done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_qready", int'(Q_ready), 1);
        chk("rst_re", int'(Ainv_re), 0);
        chk("rst_im", int'(Ainv_im), 0);
        chk("rst_row", int'(Ainv_row), 0);
        chk("rst_col", int'(Ainv_col), 0);
        RST = 1'b0;
        step();

        // Identity: A^-1 = I scaled by 2048
        set_identity();
        load_q(0, 15);
        start_run(BIG, s);
        chk("id_busy_s1", int'(busy), 1);
        chk("id_qready_s1", int'(Q_ready), 0);
        repeat (40) step();
        chk("id_busy_s41", int'(busy), 1);
        step();
        chk("id_busy_s42", int'(busy), 0);
        chk("id_qready_s42", int'(Q_ready), 1);
        repeat (4) step();

        // Conjugation, with a restart attempt and Q writes mid-run
        set_identity();
        g_qre[0] = 0;
        g_qim[0] = 2048;
        load_q(0, 15);
        start_run(BIG, s);
        repeat (8) step();
        drive_junk(4096);
        R_inverse_done = 1'b1;
        Q_valid = 1'b1;
        Q_re_in = 18'sd12345;
        Q_im_in = -18'sd777;
        chk("ign_qready_s9", int'(Q_ready), 0);
        step();
        R_inverse_done = 1'b0;
        Q_valid = 1'b0;
        repeat (20) step();
        chk("ign_qready_s30", int'(Q_ready), 0);
        repeat (16) step();

        // Saturation: row 0 overflows positive, then negative with the same Q
        for (int n = 0; n < 16; n++) begin
            g_qre[n] = 2048;
            g_qim[n] = 0;
        end
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                g_rre[i][k] = (i == 0) ? 122880 : 0;
                g_rim[i][k] = 0;
            end
        load_q(0, 15);
        start_run(BIG, s);
        repeat (45) step();
        for (int k = 0; k < 4; k++) g_rre[0][k] = -122880;
        start_run(BIG, s);
        repeat (45) step();

        // Wait for Q: done arrives after 10 writes, the rest follow
        set_identity();
        load_q(0, 9);
        drive_r();
        R_inverse_done = 1'b1;
        step();
        R_inverse_done = 1'b0;
        for (int n = 0; n < 3; n++) begin
            chk("wq_busy_idle", int'(busy), 0);
            step();
        end
        load_q(10, 15);
        t = cyc - 1;
        push_run(t + 1, BIG);
        chk("wq_busy_t1", int'(busy), 0);
        step();
        chk("wq_busy_t2", int'(busy), 1);
        repeat (45) step();

        // Reset at S+20, then a fresh general-valued run
        set_identity();
        load_q(0, 15);
        start_run(20, s);
        repeat (19) step();
        RST = 1'b1;
        #1;
        chk("mr_valid", int'(Ainv_valid), 0);
        chk("mr_done", int'(Ainv_done), 0);
        chk("mr_busy", int'(busy), 0);
        chk("mr_qready", int'(Q_ready), 1);
        chk("mr_re", int'(Ainv_re), 0);
        chk("mr_im", int'(Ainv_im), 0);
        chk("mr_row", int'(Ainv_row), 0);
        chk("mr_col", int'(Ainv_col), 0);
        step();
        RST = 1'b0;
        repeat (50) step();

        for (int n = 0; n < 16; n++) begin
            g_qre[n] = (n % 5) * 700 - 1400;
            g_qim[n] = 1000 - (n % 3) * 900;
        end
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                g_rre[i][k] = (k >= i) ? 1500 - 300*(k-i) + 100*i : 0;
                g_rim[i][k] = (k > i) ? (k-i)*250 - 400*i : 0;
            end
        load_q(0, 15);
        start_run(BIG, s);
        repeat (48) step();

        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
